pipe_issue: RTL
===============

Name: pipe_issue

Overview:
- Instruction issue stage directly upstream of the 4-stage pipelined 16-bit ALU (pipe_ALU).
- Accepts packed 24-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word into the ALU's rs1/rs2/rd/func/addr fields and issues at most one per clk1 edge.
- Because the ALU has no forwarding, a scoreboard holds back any instruction that reads a register still in flight.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
HAZARD_WINDOW, 2, issue slots after a writer during which a reader of its rd is held
NUM_FUNC, 12, legal func codes are 0..NUM_FUNC-1

Ports:
clk1  in  1  sole clock; one issue slot per rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  upstream word valid
instr  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
instr_ready  out  1  FIFO can accept (= !full)
flush  in  1  synchronous: discard all buffered words
rs1, rs2, rd, func  out  4 each  decoded fields to ALU stage 1
addr  out  8  memory address to ALU
issue_valid  out  1  fields valid this cycle; ALU integration qualifies regbank/mem writes with it
illegal_instr  out  1  one-cycle pulse: head word dropped because func >= NUM_FUNC
stall_cnt  out  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (async assert, sync release): FIFO empty, scoreboard all invalid, all field outputs 0, issue_valid=0, illegal_instr=0, stall_cnt=0. instr_ready=1 after reset.
- Push: a word is written on an edge where instr_valid && instr_ready. There is no push when full, even if a pop happens on the same edge; instr_ready is purely !full.
- Latency: a word pushed into an empty FIFO at edge k, with no hazard, appears on the outputs with issue_valid=1 after edge k+1. The FIFO has no combinational bypass.
- Scoreboard: shift register of HAZARD_WINDOW entries {valid, rd}. Every edge it shifts by one. The entering entry is {1, rd} when an instruction issues, otherwise {0, x}.
- Hazard: head.rs1 or head.rs2 equals the rd of any valid entry. A reader therefore issues no earlier than writer edge + HAZARD_WINDOW + 1.
- Per-edge decision for the head word, in priority order:
  - flush: clear FIFO, issue_valid=0, nothing pops.
  - empty: issue_valid=0.
  - head.func >= NUM_FUNC: pop, issue_valid=0, illegal_instr=1, scoreboard gets an invalid entry.
  - hazard: no pop, issue_valid=0, stall_cnt+1 (saturates at 16'hFFFF).
  - otherwise: pop, register fields, issue_valid=1.
- Bubble cycles drive rs1/rs2/rd/func/addr to 0.
- A push that coincides with flush is dropped.
- Wrap-around: read and write pointers are log2(FIFO_DEPTH) bits and wrap. Count is log2(FIFO_DEPTH)+1 bits. full = (count==FIFO_DEPTH), empty = (count==0).
- rd==rs1 within the same instruction is not a hazard; only earlier writers count.
- Scoreboard is not cleared by flush, since those instructions are already inside the ALU.
- Reset mid-stream drops all buffered and in-flight scoreboard state immediately.

Decomposition:
- Shared package pipe_pkg: instruction field bit positions, func enumeration (ADD=0, SUB=1, MUL=2, ..., SLA=11), INSTR_W=24, REG_ADDR_W=4, MEM_ADDR_W=8. The ALU should also import it.
- One sub-module, pipe_issue_fifo: parameterised synchronous FIFO with push/pop/flush/full/empty/count.
- Hazard check and scoreboard stay in pipe_issue.

Test Plan:
- Reset mid-stream: fill 3 words, assert rst_n=0 between edges -> outputs 0 and instr_ready=1 immediately; no stale issue after release.
- Independent stream: push 24'h0A357D (ADD r10=r3+r5, addr 125) and 24'h2C387E (MUL r12, addr 126) on consecutive edges -> issued on consecutive edges with rd=10, 12, addr=125, 126; stall_cnt=0.
- RAW hazard: push ADD 24'h0A357D, MUL 24'h2C387E, SUB 24'h1EA580 (reads r10) back-to-back. ADD issues at edge n, MUL at n+1, one bubble at n+2, SUB issues at n+3 -> stall_cnt=1.
- Full/backpressure: hold issue by making the head depend on r10 after ADD, and push 4 more -> instr_ready=0 at count 4; the 5th word is held upstream and not lost; all issue in order.
- Illegal and flush: push func=4'hF word then a valid word -> one illegal_instr pulse, the valid word issues next edge. Flush with 3 buffered -> no issue, count 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: instruction format, func codes and shared helpers for the issue stage and ALU
package pipe_pkg;
  localparam int INSTR_W = 24;
  localparam int REG_ADDR_W = 4;
  localparam int MEM_ADDR_W = 8;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB = 16;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 8;
  localparam int ADDR_LSB = 0;
  typedef enum logic [3:0] {
    ADD, SUB, MUL, SELA, SELB, AND, OR, XOR, NEGA, NEGB, SRA, SLA
  } func_e;
  typedef struct packed {
    logic [3:0] func;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [MEM_ADDR_W-1:0] addr;
  } instr_t;
  function automatic logic reads(input instr_t i, input logic [REG_ADDR_W-1:0] r);
    return i.rs1 == r || i.rs2 == r;
  endfunction
endpackage

// File: rtl/pipe_issue_if.sv
// pipe_issue_if: instruction intake handshake and decoded issue bundle
import pipe_pkg::*;
interface pipe_issue_if;
  logic instr_valid;
  logic instr_ready;
  logic flush;
  logic [INSTR_W-1:0] instr;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd, func;
  logic [MEM_ADDR_W-1:0] addr;
  logic issue_valid;
  logic illegal_instr;
  logic [15:0] stall_cnt;
  modport master (
    output instr_valid, instr, flush,
    input instr_ready, rs1, rs2, rd, func, addr, issue_valid, illegal_instr, stall_cnt
  );
  modport slave (
    input instr_valid, instr, flush,
    output instr_ready, rs1, rs2, rd, func, addr, issue_valid, illegal_instr, stall_cnt
  );
endinterface

// File: rtl/pipe_issue_fifo.sv
// pipe_issue_fifo: synchronous FIFO, no bypass, push refused when full or flushing
module pipe_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign wr = push && !full && !flush;
  assign rd = pop && !empty && !flush;
  assign dout = mem[rp];
  // storage array, no reset needed since count gates visibility
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers and occupancy; flush empties the buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: buffers instruction words and issues them to the ALU, holding RAW hazards
import pipe_pkg::*;
module pipe_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZARD_WINDOW = 2,
  parameter int NUM_FUNC = 12
) (
  input logic clk1,
  input logic rst_n,
  pipe_issue_if.slave bus
);
  instr_t head;
  logic full, empty, hazard, illegal, issue, stall;
  logic [HAZARD_WINDOW-1:0] sb_v;
  logic [REG_ADDR_W-1:0] sb_rd [HAZARD_WINDOW];
  pipe_issue_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W)) u_fifo (
    .clk(clk1),
    .rst_n(rst_n),
    .push(bus.instr_valid),
    .pop(issue || illegal),
    .flush(bus.flush),
    .din(bus.instr),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign bus.instr_ready = !full;
  assign illegal = !bus.flush && !empty && int'(head.func) >= NUM_FUNC;
  assign stall = !bus.flush && !empty && !illegal && hazard;
  assign issue = !bus.flush && !empty && !illegal && !hazard;
  // head reads a register some in-flight writer has not yet written back
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++) hazard = hazard || (sb_v[i] && reads(head, sb_rd[i]));
  end
  // in-flight writer window; flush leaves it alone since those ops are already in the ALU
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++) sb_rd[i] <= '0;
    end else begin
      sb_v[0] <= issue;
      sb_rd[0] <= issue ? head.rd : '0;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  // registered issue fields, zeroed on bubbles, plus illegal pulse and stall counter
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      bus.rs1 <= '0;
      bus.rs2 <= '0;
      bus.rd <= '0;
      bus.func <= '0;
      bus.addr <= '0;
      bus.issue_valid <= 1'b0;
      bus.illegal_instr <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      bus.rs1 <= issue ? head.rs1 : '0;
      bus.rs2 <= issue ? head.rs2 : '0;
      bus.rd <= issue ? head.rd : '0;
      bus.func <= issue ? head.func : '0;
      bus.addr <= issue ? head.addr : '0;
      bus.issue_valid <= issue;
      bus.illegal_instr <= illegal;
      bus.stall_cnt <= (stall && bus.stall_cnt != 16'hFFFF) ? bus.stall_cnt + 16'd1 : bus.stall_cnt;
    end
endmodule
